// File: rtl/phase_blender_ctrl.sv
// Hitless ramp controller for a 16-unit thermometer phase blender and its even/odd phase muxes.
// Steps the applied code one LSB per update period along the shortest circular path to the target.
module phase_blender_ctrl #(
    parameter int SEG_W   = 3,
    parameter int UPD_DIV = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEG_W+3:0] tgt_code,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    output logic             busy,
    output logic             done,
    output logic [SEG_W+3:0] cur_code,
    output logic [15:0]      thm_sel_bld,
    output logic [SEG_W-2:0] sel_even,
    output logic [SEG_W-2:0] sel_odd
);

    localparam int CW    = SEG_W + 4;
    localparam int CNT_W = (UPD_DIV > 0) ? $clog2(UPD_DIV + 1) : 1;
    localparam logic [CW-1:0]    HALF     = {1'b1, {(CW-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPD_DIV);

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        SWAP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    cur_d;
    logic [15:0]      thm_d;
    logic [SEG_W-2:0] sel_even_d, sel_odd_d;
    logic             done_d, busy_d, ready_d;

    logic [CW-1:0]    diff;
    logic             step_up;
    logic [CW-1:0]    step_code;
    logic             cross_up, cross_dn;

    // Even segments grow ones from bit 0; odd segments keep 16-f ones at the top.
    function automatic logic [15:0] code_to_thm(input logic [CW-1:0] code);
        logic [15:0] ones;
        ones = (16'd1 << code[3:0]) - 16'd1;
        return code[4] ? ~ones : ones;
    endfunction

    function automatic logic [SEG_W-2:0] even_sel_of(input logic [CW-1:0] code);
        logic [SEG_W:0] s1;
        s1 = {1'b0, code[CW-1:4]} + {{SEG_W{1'b0}}, 1'b1};
        return s1[SEG_W-1:1];
    endfunction

    function automatic logic [SEG_W-2:0] odd_sel_of(input logic [CW-1:0] code);
        return code[CW-1:5];
    endfunction

    // Shortest circular direction; an exact half-turn resolves upward.
    assign diff      = tgt_q - cur_code;
    assign step_up   = (diff == HALF) || !diff[CW-1];
    assign step_code = step_up ? cur_code + 1'b1 : cur_code - 1'b1;
    assign cross_up  = step_up && (cur_code[3:0] == 4'hF);
    assign cross_dn  = !step_up && (cur_code[3:0] == 4'h0);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        cnt_d      = cnt_q;
        cur_d      = cur_code;
        thm_d      = thm_sel_bld;
        sel_even_d = sel_even;
        sel_odd_d  = sel_odd;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d   = tgt_code;
                    cnt_d   = '0;
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (cur_code == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (cross_dn) begin
                        // Retarget the idle mux first; the code moves on the SWAP edge.
                        sel_even_d = even_sel_of(step_code);
                        sel_odd_d  = odd_sel_of(step_code);
                        state_d    = SWAP;
                    end else begin
                        cur_d = step_code;
                        thm_d = code_to_thm(step_code);
                        if (cross_up) begin
                            state_d = SWAP;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SWAP: begin
                cnt_d   = '0;
                state_d = RAMP;
                if (step_up) begin
                    // Only the select of the phase that just reached zero weight differs.
                    sel_even_d = even_sel_of(cur_code);
                    sel_odd_d  = odd_sel_of(cur_code);
                end else begin
                    cur_d = step_code;
                    thm_d = code_to_thm(step_code);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tgt_q       <= '0;
            cnt_q       <= '0;
            cur_code    <= '0;
            thm_sel_bld <= '0;
            sel_even    <= '0;
            sel_odd     <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            tgt_ready   <= 1'b1;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            cur_code    <= cur_d;
            thm_sel_bld <= thm_d;
            sel_even    <= sel_even_d;
            sel_odd     <= sel_odd_d;
            done        <= done_d;
            busy        <= busy_d;
            tgt_ready   <= ready_d;
        end
    end

    a_thm_map : assert property (@(posedge clk) disable iff (rst)
        thm_sel_bld == code_to_thm(cur_code));

    a_hitless : assert property (@(posedge clk) disable iff (rst)
        !$past(rst) |-> ($countones(thm_sel_bld ^ $past(thm_sel_bld)) <= 1));

    a_even_sel_safe : assert property (@(posedge clk) disable iff (rst)
        (!$past(rst) && (sel_even != $past(sel_even))) |->
        ($past(thm_sel_bld) == 16'hFFFF && thm_sel_bld == $past(thm_sel_bld)));

    a_odd_sel_safe : assert property (@(posedge clk) disable iff (rst)
        (!$past(rst) && (sel_odd != $past(sel_odd))) |->
        ($past(thm_sel_bld) == 16'h0000 && thm_sel_bld == $past(thm_sel_bld)));

endmodule

// File: tb/tb_phase_blender_ctrl.sv
// Bench for phase_blender_ctrl: two instances (UPD_DIV 0 and 3) share stimulus, each tracked by
// a schedule model built from the ramp rules, plus directed literal checks on key transitions.
module tb_phase_blender_ctrl;

    localparam int SW  = 3;
    localparam int CW  = SW + 4;
    localparam int NPH = 1 << SW;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] tgt_code;
    logic          tgt_valid;

    logic          tgt_ready [2];
    logic          busy      [2];
    logic          done      [2];
    logic [CW-1:0] cur_code  [2];
    logic [15:0]   thm       [2];
    logic [SW-2:0] sel_even  [2];
    logic [SW-2:0] sel_odd   [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [15:0] t2_thm [5] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Spec-level mapping: bit i is set when i < f (even segment) or i >= f (odd segment).
    function automatic logic [15:0] m_thm(input logic [CW-1:0] c);
        int f = int'(c[3:0]);
        logic [15:0] r = '0;
        for (int i = 0; i < 16; i++) r[i] = c[4] ? (i >= f) : (i < f);
        return r;
    endfunction

    function automatic logic [SW-2:0] m_se(input logic [CW-1:0] c);
        int s = int'(c[CW-1:4]);
        return (SW-1)'(((s + 1) / 2) % (NPH / 2));
    endfunction

    function automatic logic [SW-2:0] m_so(input logic [CW-1:0] c);
        int s = int'(c[CW-1:4]);
        return (SW-1)'(s / 2);
    endfunction

    typedef struct packed {
        logic [CW-1:0] cur;
        logic [SW-2:0] se;
        logic [SW-2:0] so;
        logic          dn;
        logic          bz;
    } snap_t;

    function automatic snap_t mk(input logic [CW-1:0] c, input logic [SW-2:0] se,
                                 input logic [SW-2:0] so, input logic dn, input logic bz);
        snap_t s;
        s.cur = c; s.se = se; s.so = so; s.dn = dn; s.bz = bz;
        return s;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int DIV = (g == 0) ? 0 : 3;

        phase_blender_ctrl #(.SEG_W(SW), .UPD_DIV(DIV)) dut (
            .clk        (clk),
            .rst        (rst),
            .tgt_code   (tgt_code),
            .tgt_valid  (tgt_valid),
            .tgt_ready  (tgt_ready[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .cur_code   (cur_code[g]),
            .thm_sel_bld(thm[g]),
            .sel_even   (sel_even[g]),
            .sel_odd    (sel_odd[g])
        );

        snap_t         q[$];
        snap_t         exp_s;
        logic          rst_seen;
        logic [15:0]   prev_thm;
        logic [SW-2:0] prev_se, prev_so;
        bit            prev_ok = 1'b0;

        // Expected per-edge outputs of one whole ramp, from acceptance+1 up to the done pulse.
        task automatic plan(input logic [CW-1:0] c0, input logic [CW-1:0] t);
            logic [CW-1:0] c = c0;
            logic [CW-1:0] n;
            int d = int'(t) - int'(c0);
            bit up;
            if (d < 0) d += (1 << CW);
            up = (d <= (1 << (CW - 1)));
            while (c != t) begin
                repeat (DIV) q.push_back(mk(c, m_se(c), m_so(c), 1'b0, 1'b1));
                n = up ? c + 1'b1 : c - 1'b1;
                if (up && c[3:0] == 4'hF) begin
                    q.push_back(mk(n, m_se(c), m_so(c), 1'b0, 1'b1));
                    q.push_back(mk(n, m_se(n), m_so(n), 1'b0, 1'b1));
                end else if (!up && c[3:0] == 4'h0) begin
                    q.push_back(mk(c, m_se(n), m_so(n), 1'b0, 1'b1));
                    q.push_back(mk(n, m_se(n), m_so(n), 1'b0, 1'b1));
                end else begin
                    q.push_back(mk(n, m_se(n), m_so(n), 1'b0, 1'b1));
                end
                c = n;
            end
            q.push_back(mk(t, m_se(t), m_so(t), 1'b1, 1'b0));
        endtask

        always @(posedge clk) begin
            snap_t nx;
            if (rst) begin
                q.delete();
                nx = mk('0, '0, '0, 1'b0, 1'b0);
            end else if (q.size() != 0) begin
                nx = q.pop_front();
            end else begin
                nx    = exp_s;
                nx.dn = 1'b0;
                nx.bz = 1'b0;
                if (tgt_valid) begin
                    nx.bz = 1'b1;
                    plan(exp_s.cur, tgt_code);
                end
            end
            exp_s    <= nx;
            rst_seen <= rst;
        end

        always @(negedge clk) begin
            if (chk_en) begin
                check($sformatf("u%0d.cur", g),   cur_code[g],  exp_s.cur);
                check($sformatf("u%0d.thm", g),   thm[g],       m_thm(exp_s.cur));
                check($sformatf("u%0d.se", g),    sel_even[g],  exp_s.se);
                check($sformatf("u%0d.so", g),    sel_odd[g],   exp_s.so);
                check($sformatf("u%0d.done", g),  done[g],      exp_s.dn);
                check($sformatf("u%0d.busy", g),  busy[g],      exp_s.bz);
                check($sformatf("u%0d.ready", g), tgt_ready[g], !exp_s.bz);
                if (prev_ok && !rst_seen) begin
                    check($sformatf("u%0d.hamming", g), $countones(thm[g] ^ prev_thm) <= 1, 1);
                    check($sformatf("u%0d.se_safe", g),
                          (sel_even[g] == prev_se) || (thm[g] == prev_thm && prev_thm == 16'hFFFF), 1);
                    check($sformatf("u%0d.so_safe", g),
                          (sel_odd[g] == prev_so) || (thm[g] == prev_thm && prev_thm == 16'h0000), 1);
                end
                prev_thm <= thm[g];
                prev_se  <= sel_even[g];
                prev_so  <= sel_odd[g];
                prev_ok  <= 1'b1;
            end
        end
    end

    // Called on a negedge; returns one negedge later, after the accepting edge.
    task automatic offer(input logic [CW-1:0] c);
        tgt_code  = c;
        tgt_valid = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(tgt_ready[0] && tgt_ready[1]) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", tgt_ready[0] && tgt_ready[1], 1);
    endtask

    initial begin
        int n;
        int k_pulse;
        rst       = 1'b1;
        tgt_valid = 1'b0;
        tgt_code  = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // 0 -> 5 one LSB per edge, with an ignored offer mid-ramp.
        offer(7'd5);
        check("t2_busy", busy[0], 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t2_thm%0d", i), thm[0], t2_thm[i]);
            if (i == 1) begin
                tgt_code  = 7'h40;
                tgt_valid = 1'b1;
            end
            if (i == 2) tgt_valid = 1'b0;
        end
        @(negedge clk);
        check("t2_done", done[0], 1);
        check("t2_cur", cur_code[0], 7'd5);
        @(negedge clk);
        check("t2_done_pulse", done[0], 0);
        wait_idle();

        // Up-crossing 0x0F -> 0x10.
        offer(7'h0F);
        wait_idle();
        check("t3_start_thm", thm[0], 16'h7FFF);
        offer(7'h10);
        @(negedge clk);
        check("t3_thm", thm[0], 16'hFFFF);
        check("t3_se_held", sel_even[0], 0);
        @(negedge clk);
        check("t3_se", sel_even[0], 1);
        check("t3_so", sel_odd[0], 0);
        check("t3_thm_held", thm[0], 16'hFFFF);
        @(negedge clk);
        check("t3_done", done[0], 1);
        wait_idle();

        // Down-crossing 0x10 -> 0x0F: select first, code second.
        offer(7'h0F);
        check("t4_se_before", sel_even[0], 1);
        @(negedge clk);
        check("t4_se", sel_even[0], 0);
        check("t4_thm_held", thm[0], 16'hFFFF);
        check("t4_cur_held", cur_code[0], 7'h10);
        @(negedge clk);
        check("t4_thm", thm[0], 16'h7FFF);
        check("t4_cur", cur_code[0], 7'h0F);
        @(negedge clk);
        check("t4_done", done[0], 1);
        wait_idle();

        // Wrap 0x7F -> 0x00.
        offer(7'h7F);
        wait_idle();
        check("t5_thm7f", thm[0], 16'h8000);
        check("t5_se7f", sel_even[0], 0);
        check("t5_so7f", sel_odd[0], 3);
        offer(7'h00);
        @(negedge clk);
        check("t5_thm0", thm[0], 16'h0000);
        check("t5_so_held", sel_odd[0], 3);
        @(negedge clk);
        check("t5_so0", sel_odd[0], 0);
        @(negedge clk);
        check("t5_wrap_done", done[0], 1);
        wait_idle();

        // Half-turn tie goes up: 64 steps plus 4 crossings before done.
        offer(7'd64);
        n = 0;
        while (!done[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_tie_cycles", n, 69);
        check("t5_tie_cur", cur_code[0], 7'd64);
        check("t5_tie_se", sel_even[0], 2);
        check("t5_tie_so", sel_odd[0], 2);
        wait_idle();

        // Reset mid-ramp.
        offer(7'h20);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("t1_cur%0d", g),   cur_code[g],  0);
            check($sformatf("t1_thm%0d", g),   thm[g],       0);
            check($sformatf("t1_se%0d", g),    sel_even[g],  0);
            check($sformatf("t1_so%0d", g),    sel_odd[g],   0);
            check($sformatf("t1_ready%0d", g), tgt_ready[g], 1);
            check($sformatf("t1_done%0d", g),  done[g],      0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // UPD_DIV=3 instance: one step every 4 edges, stray offer ignored.
        k_pulse = $urandom_range(1, 6);
        offer(7'd2);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t6_cur_k%0d", k), cur_code[1], k / 4);
            if (k == k_pulse) begin
                tgt_code  = 7'h33;
                tgt_valid = 1'b1;
            end else begin
                tgt_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("t6_done", done[1], 1);
        check("t6_cur", cur_code[1], 7'd2);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
